// File: rtl/seq_detect_ctrl_if.sv
// Config, control, serial-stream and status signals of the bit-pattern detector controller.
// The master drives configuration and stream; the slave (controller) returns status.
interface seq_detect_ctrl_if #(
  parameter int PAT_W = 8,
  parameter int CNT_W = 8,
  parameter int WIN_W = 16
) ();
  logic             cfg_we;
  logic [PAT_W-1:0] cfg_pattern;
  logic [3:0]       cfg_len;
  logic             cfg_overlap;
  logic [CNT_W-1:0] cfg_thresh;
  logic [WIN_W-1:0] cfg_window;
  logic             start;
  logic             abort;
  logic             in;
  logic             in_valid;
  logic             busy;
  logic             hit;
  logic [CNT_W-1:0] match_cnt;
  logic             done;
  logic             timeout;
  logic [1:0]       state_o;

  modport master (
    output cfg_we, cfg_pattern, cfg_len, cfg_overlap, cfg_thresh, cfg_window,
    output start, abort, in, in_valid,
    input  busy, hit, match_cnt, done, timeout, state_o
  );

  modport slave (
    input  cfg_we, cfg_pattern, cfg_len, cfg_overlap, cfg_thresh, cfg_window,
    input  start, abort, in, in_valid,
    output busy, hit, match_cnt, done, timeout, state_o
  );
endinterface

// File: rtl/seq_detect_ctrl.sv
// Session sequencer for the serial bit-pattern detector: holds run-time config,
// counts pattern matches on a qualified stream and ends on threshold or window expiry.
module seq_detect_ctrl #(
  parameter int PAT_W = 8,
  parameter int CNT_W = 8,
  parameter int WIN_W = 16
) (
  input  logic               clk,
  input  logic               reset,
  seq_detect_ctrl_if.slave   bus
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ARMED = 2'd1;
  localparam logic [1:0] ST_RUN   = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;
  localparam logic [3:0] LEN_MAX  = 4'(PAT_W);

  logic [1:0]       state_r, state_s;
  logic             busy_r, busy_s;
  logic             hit_r, hit_s;
  logic             done_r, done_s;
  logic             timeout_r, timeout_s;
  logic [CNT_W-1:0] cnt_r, cnt_s, cnt_inc_s;
  logic [PAT_W-1:0] shift_r, shift_s, shift_inc_s;
  logic [3:0]       fill_r, fill_s, fill_inc_s;
  logic [WIN_W-1:0] win_r, win_s, win_inc_s;
  logic [PAT_W-1:0] pat_r, pat_s;
  logic [3:0]       len_r, len_s;
  logic             ovl_r, ovl_s;
  logic [CNT_W-1:0] thr_r, thr_s;
  logic [WIN_W-1:0] wdw_r, wdw_s;
  logic [PAT_W-1:0] mask_s;
  logic             match_s;

  // Compare mask covering the low len bits of the pattern.
  always_comb begin
    mask_s = '0;
    for (int i = 0; i < PAT_W; i++) begin
      mask_s[i] = (i < int'(len_r));
    end
  end

  // Candidate values for a valid bit, and the match decision on the updated shift/fill.
  always_comb begin
    shift_inc_s = {shift_r[PAT_W-2:0], bus.in};
    fill_inc_s  = (fill_r == LEN_MAX) ? fill_r : fill_r + 4'd1;
    win_inc_s   = win_r + WIN_W'(1);
    cnt_inc_s   = (cnt_r == {CNT_W{1'b1}}) ? cnt_r : cnt_r + CNT_W'(1);
    match_s     = (fill_inc_s >= len_r) &&
                  (((shift_inc_s ^ pat_r) & mask_s) == {PAT_W{1'b0}});
  end

  // Config is writable only while no session is active; out-of-range values are clamped.
  always_comb begin
    pat_s = pat_r;
    len_s = len_r;
    ovl_s = ovl_r;
    thr_s = thr_r;
    wdw_s = wdw_r;
    if (bus.cfg_we && (state_r == ST_IDLE || state_r == ST_DONE)) begin
      pat_s = bus.cfg_pattern;
      ovl_s = bus.cfg_overlap;
      wdw_s = bus.cfg_window;
      if (bus.cfg_len == 4'd0) begin
        len_s = 4'd1;
      end else if (bus.cfg_len > LEN_MAX) begin
        len_s = LEN_MAX;
      end else begin
        len_s = bus.cfg_len;
      end
      if (bus.cfg_thresh == {CNT_W{1'b0}}) begin
        thr_s = CNT_W'(1);
      end else begin
        thr_s = bus.cfg_thresh;
      end
    end else begin
      pat_s = pat_r;
    end
  end

  // Session FSM and bit processing; abort outranks start and any bit on the same edge.
  always_comb begin
    state_s   = state_r;
    hit_s     = 1'b0;
    done_s    = done_r;
    timeout_s = timeout_r;
    cnt_s     = cnt_r;
    shift_s   = shift_r;
    fill_s    = fill_r;
    win_s     = win_r;
    case (state_r)
      ST_IDLE, ST_DONE: begin
        if (bus.start && !bus.abort) begin
          state_s   = ST_ARMED;
          done_s    = 1'b0;
          timeout_s = 1'b0;
          cnt_s     = '0;
          shift_s   = '0;
          fill_s    = 4'd0;
          win_s     = '0;
        end else begin
          state_s = state_r;
        end
      end
      ST_ARMED, ST_RUN: begin
        if (bus.abort) begin
          state_s   = ST_IDLE;
          done_s    = 1'b0;
          timeout_s = 1'b0;
        end else if (bus.in_valid) begin
          shift_s = shift_inc_s;
          win_s   = win_inc_s;
          if (match_s) begin
            hit_s  = 1'b1;
            cnt_s  = cnt_inc_s;
            fill_s = ovl_r ? fill_inc_s : 4'd0;
          end else begin
            fill_s = fill_inc_s;
          end
          if (match_s && (cnt_inc_s == thr_r)) begin
            state_s = ST_DONE;
            done_s  = 1'b1;
          end else if ((wdw_r != {WIN_W{1'b0}}) && (win_inc_s == wdw_r)) begin
            state_s   = ST_DONE;
            timeout_s = 1'b1;
          end else begin
            state_s = ST_RUN;
          end
        end else begin
          state_s = state_r;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
    busy_s = (state_s == ST_ARMED) || (state_s == ST_RUN);
  end

  // State, status and config registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r   <= ST_IDLE;
      busy_r    <= 1'b0;
      hit_r     <= 1'b0;
      done_r    <= 1'b0;
      timeout_r <= 1'b0;
      cnt_r     <= '0;
      shift_r   <= '0;
      fill_r    <= 4'd0;
      win_r     <= '0;
      pat_r     <= {PAT_W{1'b1}};
      len_r     <= 4'd4;
      ovl_r     <= 1'b1;
      thr_r     <= CNT_W'(1);
      wdw_r     <= '0;
    end else begin
      state_r   <= state_s;
      busy_r    <= busy_s;
      hit_r     <= hit_s;
      done_r    <= done_s;
      timeout_r <= timeout_s;
      cnt_r     <= cnt_s;
      shift_r   <= shift_s;
      fill_r    <= fill_s;
      win_r     <= win_s;
      pat_r     <= pat_s;
      len_r     <= len_s;
      ovl_r     <= ovl_s;
      thr_r     <= thr_s;
      wdw_r     <= wdw_s;
    end
  end

  assign bus.busy      = busy_r;
  assign bus.hit       = hit_r;
  assign bus.match_cnt = cnt_r;
  assign bus.done      = done_r;
  assign bus.timeout   = timeout_r;
  assign bus.state_o   = state_r;

endmodule

// File: tb/tb_seq_detect_ctrl.sv
// Directed-vector bench for seq_detect_ctrl; expected values are hand-computed from the behaviour description.
module tb_seq_detect_ctrl;
  logic clk;
  logic reset;
  int   checks;
  int   errors;
  logic [15:0] hv;

  seq_detect_ctrl_if #(.PAT_W(8), .CNT_W(8), .WIN_W(16)) bus ();

  seq_detect_ctrl #(.PAT_W(8), .CNT_W(8), .WIN_W(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic v, input logic b);
    bus.in_valid = v;
    bus.in       = b;
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic send(input logic [15:0] bits, input int n, output logic [15:0] h);
    h = 16'h0000;
    for (int i = 0; i < n; i++) begin
      step(1'b1, bits[n-1-i]);
      h[i] = bus.hit;
    end
  endtask

  task automatic cfg(input logic [7:0] p, input logic [3:0] l, input logic o,
                     input logic [7:0] t, input logic [15:0] w);
    bus.cfg_pattern = p;
    bus.cfg_len     = l;
    bus.cfg_overlap = o;
    bus.cfg_thresh  = t;
    bus.cfg_window  = w;
    bus.cfg_we      = 1'b1;
    @(negedge clk);
    bus.cfg_we      = 1'b0;
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic pulse_abort();
    bus.abort = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset = 1'b0;
    bus.cfg_we = 1'b0; bus.cfg_pattern = 8'h00; bus.cfg_len = 4'd0; bus.cfg_overlap = 1'b0;
    bus.cfg_thresh = 8'h00; bus.cfg_window = 16'h0000;
    bus.start = 1'b0; bus.abort = 1'b0; bus.in = 1'b0; bus.in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("rst_state", 32'(bus.state_o), 32'd0);
    check("rst_outs", {27'd0, bus.busy, bus.hit, bus.done, bus.timeout, 1'b0}, 32'd0);
    check("rst_cnt", 32'(bus.match_cnt), 32'd0);
    reset = 1'b1;
    @(negedge clk);

    // Defaults: pattern all-ones, len 4, thresh 1
    pulse_start();
    check("armed_state", 32'(bus.state_o), 32'd1);
    check("armed_busy", 32'(bus.busy), 32'd1);
    send(16'b1111, 4, hv);
    check("def_hits", 32'(hv), 32'h8);
    check("def_cnt", 32'(bus.match_cnt), 32'd1);
    check("def_done", {bus.done, bus.timeout, bus.busy}, 32'b100);
    check("def_state", 32'(bus.state_o), 32'd3);
    step(1'b0, 1'b0);
    check("def_hit_drop", 32'(bus.hit), 32'd0);
    check("def_hold", {bus.done, bus.match_cnt}, {1'b1, 8'd1});

    // Overlapping 1011 with threshold 3
    cfg(8'b0000_1011, 4'd4, 1'b1, 8'd3, 16'd0);
    pulse_start();
    check("restart_clear", {bus.done, bus.match_cnt}, 32'd0);
    send(16'b1011011011, 10, hv);
    check("ovl_hits", 32'(hv), 32'h248);
    check("ovl_cnt", 32'(bus.match_cnt), 32'd3);
    check("ovl_done", {bus.state_o, bus.done, bus.timeout}, {2'd3, 1'b1, 1'b0});

    // 101 with overlap off, then on
    cfg(8'b0000_0101, 4'd3, 1'b0, 8'd5, 16'd0);
    pulse_start();
    send(16'b10101, 5, hv);
    check("noovl_hits", 32'(hv), 32'h04);
    check("noovl_run", {bus.state_o, bus.match_cnt}, {2'd2, 8'd1});
    pulse_abort();
    check("abort_state", {bus.state_o, bus.busy, bus.done, bus.timeout}, {2'd0, 3'b000});
    check("abort_cnt_kept", 32'(bus.match_cnt), 32'd1);
    cfg(8'b0000_0101, 4'd3, 1'b1, 8'd5, 16'd0);
    pulse_start();
    send(16'b10101, 5, hv);
    check("ovl101_hits", 32'(hv), 32'h14);
    check("ovl101_cnt", 32'(bus.match_cnt), 32'd2);
    pulse_abort();

    // Window expiry without matches
    cfg(8'b0000_0011, 4'd2, 1'b1, 8'd2, 16'd6);
    pulse_start();
    send(16'b10010, 5, hv);
    check("win_pre", {bus.state_o, bus.timeout}, {2'd2, 1'b0});
    step(1'b1, 1'b0);
    check("win_hits", 32'(hv), 32'h0);
    check("win_timeout", {bus.state_o, bus.done, bus.timeout, bus.busy}, {2'd3, 3'b010});

    // Threshold and window on the same bit: done wins
    cfg(8'b0000_0011, 4'd2, 1'b1, 8'd1, 16'd6);
    pulse_start();
    send(16'b000011, 6, hv);
    check("both_hits", 32'(hv), 32'h20);
    check("both_done", {bus.state_o, bus.done, bus.timeout}, {2'd3, 1'b1, 1'b0});

    // Gaps plus an attempted config write mid-session
    cfg(8'b0000_1011, 4'd4, 1'b1, 8'd3, 16'd0);
    pulse_start();
    begin
      logic [9:0] s;
      int gap_hits;
      s = 10'b1011011011;
      hv = 16'h0000;
      gap_hits = 0;
      for (int i = 0; i < 10; i++) begin
        step(1'b1, s[9-i]);
        hv[i] = bus.hit;
        if (i % 3 == 1) begin
          step(1'b0, ~s[9-i]);
          gap_hits += int'(bus.hit);
        end
        if (i == 4) begin
          cfg(8'h00, 4'd2, 1'b0, 8'd1, 16'd1);
        end
      end
      check("gap_hits", 32'(hv), 32'h248);
      check("gap_idle_hits", 32'(gap_hits), 32'd0);
    end
    check("gap_done", {bus.state_o, bus.done, bus.match_cnt}, {2'd3, 1'b1, 8'd3});

    // Abort after two bits
    pulse_start();
    send(16'b10, 2, hv);
    check("ab2_run", 32'(bus.state_o), 32'd2);
    pulse_abort();
    check("ab2_idle", {bus.state_o, bus.busy, bus.done}, {2'd0, 2'b00});

    // start and abort together in IDLE
    bus.start = 1'b1;
    bus.abort = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    bus.abort = 1'b0;
    check("start_abort", {bus.state_o, bus.busy}, {2'd0, 1'b0});

    // Clamping: len 0 -> 1, thresh 0 -> 1
    cfg(8'b0000_0001, 4'd0, 1'b1, 8'd0, 16'd0);
    pulse_start();
    send(16'b01, 2, hv);
    check("clamp_hits", 32'(hv), 32'h2);
    check("clamp_done", {bus.state_o, bus.done, bus.match_cnt}, {2'd3, 1'b1, 8'd1});

    // Reset mid-session restores defaults
    pulse_start();
    step(1'b1, 1'b1);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    check("midrst", {bus.state_o, bus.busy, bus.match_cnt}, 32'd0);
    @(negedge clk);
    pulse_start();
    send(16'b1111, 4, hv);
    check("midrst_defaults", {hv[3:0], bus.done}, {4'b1000, 1'b1});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
